// File: rtl/image_writer.sv
// Packs processed image bytes from the pixel buffer into 32-bit little-endian words and writes them to SDRAM in bursts.
// Optional byte-mask output sdram_dqm is enabled by defining IMAGE_WRITER_BYTE_MASK_EN.
module image_writer #(
  parameter int          IMAGE_WIDTH  = 224,
  parameter int          IMAGE_HEIGHT = 224,
  parameter int          CHANNELS     = 3,
  parameter int          BURST_LEN    = 8,
  parameter logic [19:0] BASE_ADDR    = 20'h40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [19:0] buf_addr,
  output logic        buf_rd_en,
  input  logic [7:0]  buf_rd_data,
  input  logic        sdram_ready,
  output logic [19:0] sdram_addr,
  output logic [31:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
`ifdef IMAGE_WRITER_BYTE_MASK_EN
  output logic [3:0]  sdram_dqm,
`endif
  output logic        busy,
  output logic        done
);

  localparam int TOTAL       = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNELS;
  localparam int BURST_BYTES = 4 * BURST_LEN;
  localparam int IDX_W       = $clog2(BURST_BYTES);
  localparam int CNT_W       = $clog2(BURST_BYTES + 1);
  localparam int WIDX        = $clog2(BURST_LEN);
  localparam int BEAT_W      = $clog2(BURST_LEN + 1);

  localparam logic [19:0]       TOTAL20   = 20'(TOTAL);
  localparam logic [19:0]       BURST20   = 20'(BURST_BYTES);
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_BYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CMD_WAIT,
    WRITE,
    NEXT,
    FINISH
  } state_t;

  state_t                    state;
  logic [19:0]               byte_cnt;
  logic [19:0]               mem_addr;
  logic [CNT_W-1:0]          fill_left;
  logic [IDX_W-1:0]          cap_idx;
  logic                      rd_pend;
  logic [BEAT_W-1:0]         beat;
  logic [8*BURST_BYTES-1:0]  pack;

  logic [19:0]               fill_base;
  logic [19:0]               remaining;
  logic [CNT_W-1:0]          next_fill;
  logic                      fill_start;
  logic                      beat_emit;
  logic [31:0]               beat_word;

  // A new transfer always counts from byte 0, whatever byte_cnt held from the last run.
  always_comb begin
    fill_base  = (state == IDLE) ? 20'd0 : byte_cnt;
    remaining  = TOTAL20 - fill_base;
    next_fill  = (remaining >= BURST20) ? BURST_CNT : remaining[CNT_W-1:0];
    fill_start = ((state == IDLE) && start) || ((state == NEXT) && (byte_cnt < TOTAL20));
    beat_emit  = ((state == CMD_WAIT) && sdram_ready) || ((state == WRITE) && (beat != LAST_BEAT));
    beat_word  = pack[{beat[WIDX-1:0], 5'b00000} +: 32];
  end

  // Main sequencer; every output is registered here so the SDRAM pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= 20'd0;
      mem_addr     <= 20'd0;
      fill_left    <= '0;
      cap_idx      <= '0;
      rd_pend      <= 1'b0;
      beat         <= '0;
      pack         <= '0;
      buf_addr     <= 20'd0;
      buf_rd_en    <= 1'b0;
      sdram_addr   <= 20'd0;
      sdram_dq_out <= 32'd0;
      sdram_dq_oe  <= 1'b0;
      sdram_cs_n   <= 1'b1;
      sdram_ras_n  <= 1'b1;
      sdram_cas_n  <= 1'b1;
      sdram_we_n   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            busy      <= 1'b1;
            byte_cnt  <= 20'd0;
            mem_addr  <= BASE_ADDR;
            fill_left <= next_fill;
            cap_idx   <= '0;
            rd_pend   <= 1'b0;
            pack      <= '0;
            state     <= FILL;
          end
        end

        // Reads stream out back to back; each byte is captured the cycle after its strobe.
        FILL: begin
          rd_pend <= buf_rd_en;
          if (fill_left != '0) begin
            buf_rd_en <= 1'b1;
            buf_addr  <= byte_cnt;
            byte_cnt  <= byte_cnt + 20'd1;
            fill_left <= fill_left - 1'b1;
          end else begin
            buf_rd_en <= 1'b0;
          end
          if (rd_pend) begin
            pack[{cap_idx, 3'b000} +: 8] <= buf_rd_data;
            cap_idx                      <= cap_idx + 1'b1;
          end
          if (rd_pend && !buf_rd_en && (fill_left == '0)) begin
            state <= CMD_WAIT;
          end
        end

        CMD_WAIT: begin
          if (beat_emit) begin
            state        <= WRITE;
            sdram_cs_n   <= 1'b0;
            sdram_ras_n  <= 1'b1;
            sdram_cas_n  <= 1'b0;
            sdram_we_n   <= 1'b0;
            sdram_addr   <= mem_addr;
            sdram_dq_out <= beat_word;
            sdram_dq_oe  <= 1'b1;
            beat         <= beat + 1'b1;
          end
        end

        // Burst always runs its full length; pad words simply carry zeros.
        WRITE: begin
          if (beat_emit) begin
            sdram_cs_n   <= 1'b0;
            sdram_ras_n  <= 1'b1;
            sdram_cas_n  <= 1'b1;
            sdram_we_n   <= 1'b1;
            sdram_dq_out <= beat_word;
            sdram_dq_oe  <= 1'b1;
            beat         <= beat + 1'b1;
          end else begin
            state        <= NEXT;
            sdram_cs_n   <= 1'b1;
            sdram_ras_n  <= 1'b1;
            sdram_cas_n  <= 1'b1;
            sdram_we_n   <= 1'b1;
            sdram_dq_out <= 32'd0;
            sdram_dq_oe  <= 1'b0;
            mem_addr     <= mem_addr + BURST20;
            beat         <= '0;
          end
        end

        NEXT: begin
          if (fill_start) begin
            state     <= FILL;
            fill_left <= next_fill;
            cap_idx   <= '0;
            rd_pend   <= 1'b0;
            pack      <= '0;
          end else begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IMAGE_WRITER_BYTE_MASK_EN
  logic [CNT_W-1:0] fill_cnt;
  logic [3:0]       beat_mask;

  // Bytes at or beyond the number actually fetched for this burst are masked off.
  always_comb begin
    beat_mask = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      beat_mask[b] = ({1'b0, beat[WIDX-1:0], 2'(b)} >= fill_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt  <= '0;
      sdram_dqm <= 4'b0000;
    end else begin
      if (fill_start) begin
        fill_cnt <= next_fill;
      end
      sdram_dqm <= beat_emit ? beat_mask : 4'b0000;
    end
  end
`endif

endmodule
